// File: rtl/alu_pkg.sv
// alu_pkg: function codes, FSM state type and multi-cycle op decode shared by alu_seq.
// Optional feature macro: ALU_DIVU_EN (makes DIVU a multi-cycle op).
package alu_pkg;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    function automatic logic is_multicycle(input logic [5:0] code);
`ifdef ALU_DIVU_EN
        return code == F_MULTU || code == F_DIVU;
`else
        return code == F_MULTU;
`endif
    endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: WIDTH-step shift-add multiplier (and restoring divider with ALU_DIVU_EN).
// Ports: clk, reset (sync, active-high); start latches a/b and op (1 = divide);
//        done is high during the final step; hi/lo hold the product or remainder/quotient.
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [WIDTH-1:0] hi_q, lo_q, b_q, hi_d, lo_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [WIDTH:0]   sum;

    assign done = busy_q && cnt_q == CNT_W'(WIDTH - 1);
    assign hi   = hi_q;
    assign lo   = lo_q;
    // Multiplier lives in lo and shifts out as product bits shift in from the top.
    assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

`ifdef ALU_DIVU_EN
    logic             op_q, ge;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] dif;
    // Restoring step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
    assign sh   = {hi_q, lo_q[WIDTH-1]};
    assign ge   = sh >= {1'b0, b_q};
    assign dif  = sh[WIDTH-1:0] - b_q;
    assign hi_d = op_q ? (ge ? dif : sh[WIDTH-1:0]) : sum[WIDTH:1];
    assign lo_d = op_q ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
    always_ff @(posedge clk)
        if (reset)      op_q <= 1'b0;
        else if (start) op_q <= op;
`else
    logic unused_op;
    assign unused_op = op;
    assign hi_d = sum[WIDTH:1];
    assign lo_d = {sum[0], lo_q[WIDTH-1:1]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            hi_q   <= '0;
            lo_q   <= a;
            b_q    <= b;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_q + 1'b1;
            busy_q <= !done;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshake, flags and iterative MULTU/DIVU.
// Ports: clk, reset (sync, active-high); in_valid/in_ready request handshake; Signal function code;
//        dataA/dataB operands; out_valid result pulse; dataOut/hi results; zero/overflow/illegal flags.
// Optional feature macro: ALU_DIVU_EN (DIVU support; otherwise DIVU is illegal).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);
    localparam int SH = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    state_t           state_q, state_d;
    logic             acc, start, iter_done, legal, ovf_add, ovf_sub, ovf;
    logic [WIDTH-1:0] sum, diff, res, it_hi, it_lo;
    logic [WIDTH-1:0] dout_q, hi_q;
    logic             vld_q, zero_q, ovf_q, ill_q;

    assign in_ready  = state_q == IDLE;
    assign acc       = in_valid && in_ready;
    assign start     = acc && is_multicycle(Signal);
    assign state_d   = state_q == IDLE ? (start ? ITER : IDLE) :
                       state_q == ITER ? (iter_done ? DONE : ITER) : IDLE;

    assign sum       = dataA + dataB;
    assign diff      = dataA - dataB;
    assign ovf_add   = dataA[M] == dataB[M] && sum[M] != dataA[M];
    assign ovf_sub   = dataA[M] != dataB[M] && diff[M] != dataA[M];
    assign legal     = Signal inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL};
    assign ovf       = Signal == F_ADD ? ovf_add : Signal == F_SUB ? ovf_sub : 1'b0;
    assign res       = Signal == F_AND ? dataA & dataB :
                       Signal == F_OR  ? dataA | dataB :
                       Signal == F_ADD ? sum :
                       Signal == F_SUB ? diff :
                       Signal == F_SLT ? {{(WIDTH-1){1'b0}}, diff[M] ^ ovf_sub} :
                       Signal == F_SRL ? dataA >> dataB[SH-1:0] : '0;

    assign out_valid = vld_q;
    assign dataOut   = dout_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

    alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (Signal == F_DIVU),
        .a     (dataA),
        .b     (dataB),
        .done  (iter_done),
        .hi    (it_hi),
        .lo    (it_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            dout_q  <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= 1'b0;
            if (acc && !start) begin
                vld_q  <= 1'b1;
                dout_q <= res;
                hi_q   <= '0;
                zero_q <= res == '0;
                ovf_q  <= legal && ovf;
                ill_q  <= !legal;
            end else if (state_q == DONE) begin
                vld_q  <= 1'b1;
                dout_q <= it_lo;
                hi_q   <= it_hi;
                zero_q <= it_lo == '0;
                ovf_q  <= 1'b0;
                ill_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32).
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
    logic         in_ready, out_valid, zero, overflow, illegal;
    logic [5:0]   Signal = '0;
    logic [W-1:0] dataA = '0, dataB = '0, dataOut, hi;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .Signal(Signal),
        .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .dataOut(dataOut), .hi(hi),
        .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid, zero, overflow, illegal} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=10000", {in_ready, out_valid, zero, overflow, illegal});
        end
        checks++;
        if (dataOut !== '0 || hi !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h exp=0/0", hi, dataOut);
        end
    endtask

    task automatic test_add_overflow;
        Signal = 6'd32; dataA = 32'h7FFF_FFFF; dataB = 32'h1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, overflow, zero, illegal} !== 4'b1100 || dataOut !== 32'h8000_0000 || hi !== '0) begin
            errors++;
            $display("FAIL add_ovf got v/o/z/i=%b out=%h hi=%h exp=1100 out=80000000 hi=0",
                     {out_valid, overflow, zero, illegal}, dataOut, hi);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || dataOut !== 32'h8000_0000 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL add_hold got v=%b out=%h o=%b exp v=0 out=80000000 o=1", out_valid, dataOut, overflow);
        end
    endtask

    task automatic test_slt_back_to_back;
        Signal = 6'd42; dataA = 32'h7FFF_FFFF; dataB = 32'h8000_0000; in_valid = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || dataOut !== 32'h0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL slt_pos_neg got v=%b out=%h o=%b exp v=1 out=0 o=0", out_valid, dataOut, overflow);
        end
        dataA = 32'hFFFF_FFFF; dataB = 32'h1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dataOut !== 32'h1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL slt_neg_pos got v=%b out=%h rdy=%b exp v=1 out=1 rdy=1", out_valid, dataOut, in_ready);
        end
    endtask

    task automatic test_single_ops;
        logic [5:0]   code [8] = '{6'd34, 6'd34, 6'd36, 6'd37, 6'd2, 6'd2, 6'd32, 6'd34};
        logic [W-1:0] va   [8] = '{32'h8000_0000, 32'h5, 32'hF0F0_1234, 32'hF000_0000,
                                   32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [W-1:0] vb   [8] = '{32'h1, 32'h5, 32'h0FF0_FFFF, 32'h0000_000F,
                                   32'h1F, 32'hFFFF_FFE5, 32'h1, 32'hFFFF_FFFF};
        logic [W-1:0] ex   [8] = '{32'h7FFF_FFFF, 32'h0, 32'h00F0_1234, 32'hF000_000F,
                                   32'h1, 32'h07FF_FFFF, 32'h0, 32'h8000_0000};
        logic         eo   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Signal = code[i]; dataA = va[i]; dataB = vb[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || dataOut !== ex[i] || overflow !== eo[i] ||
                zero !== (ex[i] == '0) || illegal !== 1'b0 || hi !== '0) begin
                errors++;
                $display("FAIL single_op%0d got v=%b out=%h o=%b z=%b i=%b hi=%h exp v=1 out=%h o=%b z=%b i=0 hi=0",
                         i, out_valid, dataOut, overflow, zero, illegal, hi, ex[i], eo[i], ex[i] == '0);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_multu;
        logic bad = 1'b0;
        Signal = 6'd25; dataA = 32'hFFFF_FFFF; dataB = 32'h2; in_valid = 1'b1;
        tick();
        Signal = 6'd34; dataA = 32'd10; dataB = 32'd3;
        for (int i = 0; i <= W; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL multu_busy got early ready/valid during %0d busy cycles exp rdy=0 v=0", W + 1);
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || hi !== 32'h1 || dataOut !== 32'hFFFF_FFFE || overflow !== 1'b0) begin
            errors++;
            $display("FAIL multu_result got v=%b rdy=%b hi=%h lo=%h o=%b exp v=1 rdy=1 hi=1 lo=fffffffe o=0",
                     out_valid, in_ready, hi, dataOut, overflow);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dataOut !== 32'd7 || hi !== '0) begin
            errors++;
            $display("FAIL multu_queued_sub got v=%b out=%h hi=%h exp v=1 out=7 hi=0", out_valid, dataOut, hi);
        end
        Signal = 6'd25; dataA = 32'hFFFF_FFFF; dataB = 32'hFFFF_FFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && out_valid !== 1'b1; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || hi !== 32'hFFFF_FFFE || dataOut !== 32'h1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL multu_max got v=%b hi=%h lo=%h z=%b exp v=1 hi=fffffffe lo=1 z=0", out_valid, hi, dataOut, zero);
        end
        tick();
    endtask

    task automatic test_reset_abort;
        logic seen = 1'b0;
        Signal = 6'd25; dataA = 32'd5; dataB = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dataOut !== '0 || hi !== '0) begin
            errors++;
            $display("FAIL abort_state got rdy=%b v=%b out=%h hi=%h exp rdy=1 v=0 out=0 hi=0", in_ready, out_valid, dataOut, hi);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_valid got out_valid pulse after abort exp none");
        end
    endtask

    task automatic test_illegal;
        Signal = 6'd32; dataA = 32'd2; dataB = 32'd3; in_valid = 1'b1;
        tick();
        checks++;
        if (dataOut !== 32'd5 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL pre_illegal_add got out=%h i=%b exp out=5 i=0", dataOut, illegal);
        end
        Signal = 6'd0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || dataOut !== '0 || hi !== '0) begin
            errors++;
            $display("FAIL illegal_code got v=%b i=%b out=%h hi=%h exp v=1 i=1 out=0 hi=0", out_valid, illegal, dataOut, hi);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_hold got v=%b i=%b exp v=0 i=1", out_valid, illegal);
        end
    endtask

    task automatic test_divu;
`ifdef ALU_DIVU_EN
        Signal = 6'd27; dataA = 32'd7; dataB = 32'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && out_valid !== 1'b1; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || dataOut !== 32'd3 || hi !== 32'd1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL divu_7_2 got v=%b q=%h r=%h i=%b exp v=1 q=3 r=1 i=0", out_valid, dataOut, hi, illegal);
        end
        tick();
        Signal = 6'd27; dataA = 32'd9; dataB = 32'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && out_valid !== 1'b1; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || dataOut !== 32'hFFFF_FFFF || hi !== 32'd9 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL divu_by_zero got v=%b q=%h r=%h i=%b exp v=1 q=ffffffff r=9 i=0", out_valid, dataOut, hi, illegal);
        end
`else
        Signal = 6'd27; dataA = 32'd7; dataB = 32'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || dataOut !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL divu_illegal got v=%b i=%b out=%h rdy=%b exp v=1 i=1 out=0 rdy=1", out_valid, illegal, dataOut, in_ready);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_slt_back_to_back();
        test_single_ops();
        test_multu();
        test_reset_abort();
        test_illegal();
        test_divu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
